// File: rtl/fp_normalize_pipe.sv
// Post-add/sub normaliser: leading-one search, left shift, exponent adjust and
// zero/underflow/overflow classification in a 3-stage valid/ready pipeline.
module fp_normalize_pipe #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 24,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EXP_W-1:0]  exp_in,
  input  logic [FRAC_W:0]   frac_in,
  input  logic [TAG_W-1:0]  tag_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EXP_W-1:0]  exp_out,
  output logic [FRAC_W-1:0] frac_out,
  output logic              round_bit,
  output logic              zero_flag,
  output logic              uflow_flag,
  output logic              oflow_flag,
  output logic [TAG_W-1:0]  tag_out
);
  localparam int NW = $clog2(FRAC_W + 1);
  localparam int XW = EXP_W + 2;
  localparam logic signed [XW-1:0] EXP_MAX = XW'((2 ** EXP_W) - 1);

  typedef struct packed {
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W:0]   frac;
    logic [TAG_W-1:0]  tag;
  } s1_t;

  typedef struct packed {
    logic [XW-1:0]     exp_ext;
    logic [FRAC_W:0]   sh;
    logic              zero;
    logic [TAG_W-1:0]  tag;
  } s2_t;

  typedef struct packed {
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
    logic              rnd;
    logic              zero;
    logic              uflow;
    logic              oflow;
    logic [TAG_W-1:0]  tag;
  } s3_t;

  logic [3:1] vld_pipe;
  logic [3:1] rdy;
  s1_t        s1_q;
  s2_t        s2_q, s2_d;
  s3_t        s3_q, s3_d;
  logic [NW-1:0] n;

  // Ready ripples back from the consumer so a full pipe still moves every cycle.
  assign rdy[3]   = !vld_pipe[3] || out_ready;
  assign rdy[2]   = !vld_pipe[2] || rdy[3];
  assign rdy[1]   = !vld_pipe[1] || rdy[2];
  assign in_ready = rdy[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else begin
      if (rdy[1]) vld_pipe[1] <= in_valid;
      if (rdy[2]) vld_pipe[2] <= vld_pipe[1];
      if (rdy[3]) vld_pipe[3] <= vld_pipe[2];
    end
  end

  function automatic logic [NW-1:0] lzc(input logic [FRAC_W:0] f);
    logic [NW-1:0] r;
    r = NW'(FRAC_W);
    for (int i = 0; i <= FRAC_W; i++)
      if (f[i]) r = NW'(FRAC_W - i);
    return r;
  endfunction

  // S1: input capture
  always_ff @(posedge clk) begin
    if (rdy[1] && in_valid) s1_q <= '{exp: exp_in, frac: frac_in, tag: tag_in};
  end

  // S2: shift and exponent adjust, widened so the result never wraps
  always_comb begin
    n            = lzc(s1_q.frac);
    s2_d.sh      = s1_q.frac << n;
    s2_d.exp_ext = {2'b00, s1_q.exp} + XW'(1) - {{(XW-NW){1'b0}}, n};
    s2_d.zero    = (s1_q.frac == '0);
    s2_d.tag     = s1_q.tag;
  end

  always_ff @(posedge clk) begin
    if (rdy[2] && vld_pipe[1]) s2_q <= s2_d;
  end

  // S3: classification, zero > underflow > overflow > normal
  always_comb begin
    s3_d     = '0;
    s3_d.tag = s2_q.tag;
    if (s2_q.zero) begin
      s3_d.zero = 1'b1;
    end else if ($signed(s2_q.exp_ext) <= 0) begin
      s3_d.uflow = 1'b1;
    end else if ($signed(s2_q.exp_ext) >= EXP_MAX) begin
      s3_d.oflow = 1'b1;
      s3_d.exp   = '1;
    end else begin
      s3_d.exp  = s2_q.exp_ext[EXP_W-1:0];
      s3_d.frac = s2_q.sh[FRAC_W:1];
      s3_d.rnd  = s2_q.sh[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     s3_q <= '0;
    else if (rdy[3] && vld_pipe[2]) s3_q <= s3_d;
  end

  assign out_valid  = vld_pipe[3];
  assign exp_out    = s3_q.exp;
  assign frac_out   = s3_q.frac;
  assign round_bit  = s3_q.rnd;
  assign zero_flag  = s3_q.zero;
  assign uflow_flag = s3_q.uflow;
  assign oflow_flag = s3_q.oflow;
  assign tag_out    = s3_q.tag;
endmodule

// File: tb/tb_fp_normalize_pipe.sv
// Directed-vector bench for fp_normalize_pipe: table of single words, a stall/stream
// sequence and a mid-stream reset sequence.
module tb_fp_normalize_pipe;
  logic        clk = 0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  exp_in, exp_out;
  logic [24:0] frac_in;
  logic [23:0] frac_out;
  logic [3:0]  tag_in, tag_out;
  logic        round_bit, zero_flag, uflow_flag, oflow_flag;

  int checks = 0;
  int errors = 0;

  fp_normalize_pipe #(.EXP_W(8), .FRAC_W(24), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .exp_in(exp_in), .frac_in(frac_in), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .exp_out(exp_out), .frac_out(frac_out), .round_bit(round_bit),
    .zero_flag(zero_flag), .uflow_flag(uflow_flag), .oflow_flag(oflow_flag),
    .tag_out(tag_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  e;
    logic [24:0] f;
    logic [7:0]  xe;
    logic [23:0] xf;
    logic        xr, xz, xu, xo;
  } vec_t;

  localparam int NV = 14;
  vec_t vt[NV];

  function automatic vec_t mk(logic [7:0] e, logic [24:0] f, logic [7:0] xe,
                              logic [23:0] xf, logic xr, logic xz, logic xu, logic xo);
    vec_t v;
    v.e = e; v.f = f; v.xe = xe; v.xf = xf;
    v.xr = xr; v.xz = xz; v.xu = xu; v.xo = xo;
    return v;
  endfunction

  function automatic logic [63:0] got();
    return 64'({exp_out, frac_out, round_bit, zero_flag, uflow_flag, oflow_flag});
  endfunction

  function automatic logic [63:0] want(vec_t v);
    return 64'({v.xe, v.xf, v.xr, v.xz, v.xu, v.xo});
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Push one word with out_ready high; returns edges from accept to out_valid.
  task automatic run_one(input int i, input logic [3:0] tag, output int lat);
    @(negedge clk);
    exp_in = vt[i].e; frac_in = vt[i].f; tag_in = tag;
    in_valid = 1; out_ready = 1;
    #1 chk($sformatf("in_ready_%0d", i), 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
    end
    chk($sformatf("vec%0d_data", i), got(), want(vt[i]));
    chk($sformatf("vec%0d_tag", i), 64'(tag_out), 64'(tag));
    @(posedge clk);
  endtask

  initial begin
    int lat, sent, rcvd, first, last;
    logic [63:0] held;

    vt[0]  = mk(8'd127, 25'h1000000, 8'd128, 24'h800000, 0, 0, 0, 0);
    vt[1]  = mk(8'd127, 25'h0800000, 8'd127, 24'h800000, 0, 0, 0, 0);
    vt[2]  = mk(8'd127, 25'h1000001, 8'd128, 24'h800000, 1, 0, 0, 0);
    vt[3]  = mk(8'd50,  25'h0000000, 8'd0,   24'h000000, 0, 1, 0, 0);
    vt[4]  = mk(8'd10,  25'h0000001, 8'd0,   24'h000000, 0, 0, 1, 0);
    vt[5]  = mk(8'd23,  25'h0000001, 8'd0,   24'h000000, 0, 0, 1, 0);
    vt[6]  = mk(8'd254, 25'h1FFFFFF, 8'hFF,  24'h000000, 0, 0, 0, 1);
    vt[7]  = mk(8'd253, 25'h1FFFFFF, 8'd254, 24'hFFFFFF, 1, 0, 0, 0);
    vt[8]  = mk(8'd0,   25'h0800000, 8'd0,   24'h000000, 0, 0, 1, 0);
    vt[9]  = mk(8'd0,   25'h1000000, 8'd1,   24'h800000, 0, 0, 0, 0);
    vt[10] = mk(8'd100, 25'h0000003, 8'd78,  24'hC00000, 0, 0, 0, 0);
    vt[11] = mk(8'd24,  25'h0000001, 8'd1,   24'h800000, 0, 0, 0, 0);
    vt[12] = mk(8'd254, 25'h0800000, 8'd254, 24'h800000, 0, 0, 0, 0);
    vt[13] = mk(8'd254, 25'h1000000, 8'hFF,  24'h000000, 0, 0, 0, 1);

    rst_n = 0; in_valid = 0; out_ready = 0;
    exp_in = 0; frac_in = 0; tag_in = 0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_outputs", got(), 64'd0);
    chk("rst_tag", 64'(tag_out), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);

    for (int i = 0; i < NV; i++) begin
      run_one(i, 4'(i), lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd3);
    end

    // Stall with out_ready low for 5 cycles, then stream.
    sent = 0; rcvd = 0; first = -1; last = -1; held = '0;
    for (int cyc = 0; cyc < 60 && rcvd < 6; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      in_valid  = (sent < 6);
      if (sent < 6) begin
        exp_in = vt[sent].e; frac_in = vt[sent].f; tag_in = 4'(sent + 1);
      end
      #1;
      if (cyc == 3) begin
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("stall_accepted", 64'(sent), 64'd3);
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        held = {got(), 4'b0, tag_out} ;
      end
      if (cyc == 4) chk("stall_hold", {got(), 4'b0, tag_out}, held);
      if (out_valid && out_ready) begin
        chk($sformatf("stream%0d_tag", rcvd), 64'(tag_out), 64'(rcvd + 1));
        chk($sformatf("stream%0d_data", rcvd), got(), want(vt[rcvd]));
        if (first < 0) first = cyc;
        last = cyc;
        rcvd++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 0;
    chk("stream_count", 64'(rcvd), 64'd6);
    chk("stream_first_cycle", 64'(first), 64'd5);
    chk("stream_back_to_back", 64'(last - first), 64'd5);

    // Fill with 3 words, then reset mid-stream.
    @(negedge clk);
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1; exp_in = vt[k].e; frac_in = vt[k].f; tag_in = 4'(k + 10);
      @(negedge clk);
    end
    in_valid = 0;
    chk("pre_rst_full", 64'({out_valid, in_ready}), 64'b10);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_outputs", got(), 64'd0);
    chk("mid_rst_tag", 64'(tag_out), 64'd0);
    @(negedge clk);
    rst_n = 1;
    run_one(9, 4'd7, lat);
    chk("after_rst_latency", 64'(lat), 64'd3);
    rcvd = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) rcvd++;
    end
    chk("after_rst_no_stale", 64'(rcvd), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_normalize_pipe.md
# fp_normalize_pipe

Pipelined, parametrised post-add/sub normaliser for the floating-point add/sub datapath. Takes the raw adder result (exponent plus a fraction with one carry bit) and performs a leading-one search, a left shift and an exponent adjust. Adds zero, underflow (flush-to-zero) and overflow (saturate to all-ones exponent) classification, plus a round bit for a downstream rounder. It sits between the mantissa adder and the rounding/packing stage, with a valid/ready handshake and a sideband tag carried through.

## Interface
- EXP_W, 8, exponent width
- FRAC_W, 24, output fraction width incl. hidden bit; input fraction is FRAC_W+1 bits
- TAG_W, 4, sideband tag width, passed through unchanged
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept input this cycle
- exp_in  in  EXP_W  biased exponent before normalisation
- frac_in  in  FRAC_W+1  unnormalised fraction, MSB is carry position
- tag_in  in  TAG_W  sideband
- out_valid  out  1  output word valid
- out_ready  in  1  consumer accepts output this cycle
- exp_out  out  EXP_W  normalised exponent
- frac_out  out  FRAC_W  normalised fraction, MSB = hidden 1 unless zero/underflow/overflow
- round_bit  out  1  bit shifted out below frac_out LSB
- zero_flag, uflow_flag, oflow_flag  out  1 each  classification
- tag_out  out  TAG_W  tag of the word on the output

## Operation
- n = leading-zero count of frac_in over FRAC_W+1 bits, range 0..FRAC_W; frac_in==0 yields zero case.
- sh = frac_in << n (FRAC_W+1 bits). frac_out = sh[FRAC_W:1], round_bit = sh[0].
- exp_ext = exp_in + 1 - n, evaluated signed in EXP_W+2 bits, no wrap.
- Priority of classification:
  - zero: frac_in==0 -> exp_out=0, frac_out=0, round_bit=0, zero_flag=1.
  - underflow: exp_ext <= 0 -> exp_out=0, frac_out=0, round_bit=0, uflow_flag=1 (flush-to-zero).
  - overflow: exp_ext >= 2^EXP_W-1 -> exp_out=all ones, frac_out=0, round_bit=0, oflow_flag=1.
  - normal: exp_out=exp_ext[EXP_W-1:0], frac_out/round_bit as above, all flags 0.
- At most one flag is set per output word.
- Pipeline stages:
  - S1 registers the input and computes n.
  - S2 registers the shifted fraction and exp_ext.
  - S3 registers the classified result (the output registers).
- Each stage has a valid bit. A stage loads when it is empty or when its contents move on in the same cycle. in_ready = S1 can load. Ready is a combinational chain from out_ready. No bubbles when out_ready=1.
- Transfer occurs on a cycle where valid&&ready. Order is preserved; no word is dropped or duplicated.

## Timing
- Latency 3 cycles from input handshake to out_valid with out_ready held high; throughput 1 word/cycle.
- With out_ready=0 the pipe fills with 3 words; in_ready falls in the cycle after the third accept. Outputs hold stable while out_valid=1 and out_ready=0.
- Simultaneous accept at the input and drain at the output when full: allowed, no stall cycle.
- Reset (asynchronous assert, any time including mid-stream): all stage valids=0, out_valid=0, exp_out=0, frac_out=0, round_bit=0, all flags=0, tag_out=0. in_ready=1 from the first cycle after release. In-flight words are discarded.
- Data registers need not reset, but outputs are driven only from reset registers.

## Test plan
- exp_in=127, frac_in=25'h1000000 -> after 3 cycles exp_out=128, frac_out=24'h800000, round_bit=0, flags 0; same with frac_in=25'h0800000 -> exp_out=127, frac_out=24'h800000.
- exp_in=127, frac_in=25'h1000001 -> exp_out=128, frac_out=24'h800000, round_bit=1.
- frac_in=0, exp_in=50 -> zero_flag=1, exp_out=0, frac_out=0. exp_in=10, frac_in=25'h0000001 (exp_ext=-13) -> uflow_flag=1, exp_out=0, frac_out=0. exp_in=23, frac_in=25'h0000001 (exp_ext=0) -> uflow_flag=1.
- exp_in=254, frac_in=25'h1FFFFFF -> oflow_flag=1, exp_out=8'hFF, frac_out=0, round_bit=0. exp_in=253, same frac -> exp_out=254, frac_out=24'hFFFFFF, round_bit=1, flags 0.
- Stream 6 words with tags 1..6, out_ready=0 for 5 cycles, then 1 -> exactly 3 accepted before in_ready=0, outputs held stable. All 6 emerge in tag order with correct data; back-to-back with out_ready=1 gives 1 word/cycle.
- Assert rst_n=0 with 3 words in flight -> out_valid=0 immediately and all outputs 0. After release, a new word emerges 3 cycles after accept with no stale words.
